// File: rtl/wb_modport_pkg.sv
// Shared types and constants for the Wishbone-to-application request bridge.
package wb_modport_pkg;

  localparam int DEF_APP_AW    = 26;
  localparam int DEF_DW        = 32;
  localparam int DEF_APP_RW    = 9;
  localparam int DEF_BURST_LEN = 8;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WDATA,
    RDATA,
    DRAIN
  } state_e;

endpackage

// File: rtl/wb_modport_len.sv
// Burst length: min(BURST_LEN, words left in the column page); 1 for single transfers.
// Purely combinational; page is 2^(8+colbits) words.
module wb_modport_len
  import wb_modport_pkg::*;
#(
  parameter int APP_RW    = DEF_APP_RW,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic              burst_i,
  input  logic [1:0]        colbits_i,
  input  logic [10:0]       word_addr_i,
  output logic [APP_RW-1:0] len_o
);

  logic [11:0] page_words;
  logic [11:0] offset;
  logic [11:0] remain;

  always_comb begin
    page_words = 12'd256 << colbits_i;
    offset     = {1'b0, word_addr_i} & (page_words - 12'd1);
    remain     = page_words - offset;
    len_o      = APP_RW'(1);
    if (burst_i) begin
      len_o = (remain > 12'(BURST_LEN)) ? APP_RW'(BURST_LEN) : APP_RW'(remain);
    end
  end

endmodule

// File: rtl/wb_modport.sv
// Wishbone slave to application request/data bridge; write ack is same-cycle, read ack 1 cycle after app_rd_valid.
// Multi-beat INCR bursts only when WB_MODPORT_BURST_EN is defined; otherwise every beat is a single request.
module wb_modport
  import wb_modport_pkg::*;
#(
  parameter int APP_AW    = DEF_APP_AW,
  parameter int dw        = DEF_DW,
  parameter int APP_RW    = DEF_APP_RW,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic                wb_clk,
  input  logic                wb_rst,
  input  logic                wb_cyc,
  input  logic                wb_stb,
  input  logic                wb_we,
  input  logic [dw/8-1:0]     wb_sel,
  input  logic [APP_AW-1:0]   wb_addr,
  input  logic [dw-1:0]       wb_dati,
  input  logic [2:0]          wb_cti,
  output logic [dw-1:0]       wb_dato,
  output logic                wb_ack,
  input  logic [1:0]          cfg_colbits,
  output logic                app_req,
  output logic [APP_AW-3:0]   app_req_addr,
  output logic [APP_RW-1:0]   app_req_len,
  output logic                app_req_wr_n,
  input  logic                app_req_ack,
  output logic [dw-1:0]       app_wr_data,
  output logic [dw/8-1:0]     app_wr_en_n,
  input  logic                app_wr_next,
  input  logic [dw-1:0]       app_rd_data,
  input  logic                app_rd_valid
);

  state_e              state_q, state_d;
  logic [APP_AW-3:0]   addr_q, addr_d;
  logic [APP_RW-1:0]   len_q, len_d;
  logic [APP_RW-1:0]   cnt_q, cnt_d;
  logic [APP_RW-1:0]   cnt_inc;
  logic [APP_RW-1:0]   burst_len;
  logic                wr_n_q, wr_n_d;
  logic                rd_ack_q, rd_ack_d;
  logic [dw-1:0]       dato_q, dato_d;
  logic                wr_ack;
  logic [dw/8-1:0]     wr_en_n;
  logic                burst;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^wb_addr[1:0];

`ifdef WB_MODPORT_BURST_EN
  assign burst = (wb_cti == CTI_INCR);
`else
  assign burst = 1'b0;
`endif

  wb_modport_len #(
    .APP_RW    (APP_RW),
    .BURST_LEN (BURST_LEN)
  ) u_len (
    .burst_i     (burst),
    .colbits_i   (cfg_colbits),
    .word_addr_i (wb_addr[12:2]),
    .len_o       (burst_len)
  );

  assign cnt_inc = cnt_q + APP_RW'(1);

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= APP_RW'(1);
      cnt_q    <= '0;
      wr_n_q   <= 1'b1;
      rd_ack_q <= 1'b0;
      dato_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      wr_n_q   <= wr_n_d;
      rd_ack_q <= rd_ack_d;
      dato_q   <= dato_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    wr_n_d   = wr_n_q;
    rd_ack_d = 1'b0;
    dato_d   = dato_q;
    wr_ack   = 1'b0;
    wr_en_n  = '1;
    case (state_q)
      IDLE: begin
        // The master still sees the last read ack this cycle; don't mistake it for a new request.
        if (wb_cyc && wb_stb && !rd_ack_q) begin
          addr_d  = wb_addr[APP_AW-1:2];
          wr_n_d  = ~wb_we;
          len_d   = burst_len;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (app_req_ack) begin
          state_d = wr_n_q ? RDATA : WDATA;
        end
      end
      WDATA: begin
        if (!wb_cyc) begin
          state_d = IDLE;
        end else if (wb_stb) begin
          wr_en_n = ~wb_sel;
          if (app_wr_next) begin
            wr_ack = 1'b1;
            cnt_d  = cnt_inc;
            if ((cnt_inc == len_q) || (wb_cti == CTI_END)) begin
              state_d = IDLE;
            end
          end
        end
      end
      RDATA: begin
        if (app_rd_valid) begin
          cnt_d = cnt_inc;
          if (wb_cyc) begin
            rd_ack_d = 1'b1;
            dato_d   = app_rd_data;
          end
        end
        if (app_rd_valid && (cnt_inc == len_q)) begin
          state_d = IDLE;
        end else if (!wb_cyc || (app_rd_valid && (wb_cti == CTI_END))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (app_rd_valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_ack       = wr_ack | (rd_ack_q & wb_cyc & wb_stb);
  assign wb_dato      = dato_q;
  assign app_req      = (state_q == REQ);
  assign app_req_addr = addr_q;
  assign app_req_len  = len_q;
  assign app_req_wr_n = wr_n_q;
  assign app_wr_data  = wb_dati;
  assign app_wr_en_n  = wr_en_n;

endmodule

// File: tb/tb_wb_modport.sv
// Directed bench for wb_modport; burst cases follow WB_MODPORT_BURST_EN.
module tb_wb_modport;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [25:0] wb_addr;
  logic [31:0] wb_dati;
  logic [2:0]  wb_cti;
  logic [31:0] wb_dato;
  logic        wb_ack;
  logic [1:0]  cfg_colbits;
  logic        app_req;
  logic [23:0] app_req_addr;
  logic [8:0]  app_req_len;
  logic        app_req_wr_n;
  logic        app_req_ack;
  logic [31:0] app_wr_data;
  logic [3:0]  app_wr_en_n;
  logic        app_wr_next;
  logic [31:0] app_rd_data;
  logic        app_rd_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 wb_clk = ~wb_clk;

  wb_modport dut (
    .wb_clk       (wb_clk),
    .wb_rst       (wb_rst),
    .wb_cyc       (wb_cyc),
    .wb_stb       (wb_stb),
    .wb_we        (wb_we),
    .wb_sel       (wb_sel),
    .wb_addr      (wb_addr),
    .wb_dati      (wb_dati),
    .wb_cti       (wb_cti),
    .wb_dato      (wb_dato),
    .wb_ack       (wb_ack),
    .cfg_colbits  (cfg_colbits),
    .app_req      (app_req),
    .app_req_addr (app_req_addr),
    .app_req_len  (app_req_len),
    .app_req_wr_n (app_req_wr_n),
    .app_req_ack  (app_req_ack),
    .app_wr_data  (app_wr_data),
    .app_wr_en_n  (app_wr_en_n),
    .app_wr_next  (app_wr_next),
    .app_rd_data  (app_rd_data),
    .app_rd_valid (app_rd_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start(input logic we, input logic [25:0] addr, input logic [2:0] cti);
    @(negedge wb_clk);
    wb_cyc  = 1'b1;
    wb_stb  = 1'b1;
    wb_we   = we;
    wb_addr = addr;
    wb_cti  = cti;
  endtask

  task automatic stop();
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_cti = 3'b000;
  endtask

  task automatic req_handshake(input logic [23:0] exp_addr, input logic [8:0] exp_len,
                               input logic exp_wr_n);
    int n;
    n = 0;
    while (app_req !== 1'b1 && n < 8) begin
      @(negedge wb_clk);
      n++;
    end
    chk("req_seen", {31'b0, app_req}, 32'd1);
    chk("req_addr", {8'b0, app_req_addr}, {8'b0, exp_addr});
    chk("req_len", {23'b0, app_req_len}, {23'b0, exp_len});
    chk("req_wr_n", {31'b0, app_req_wr_n}, {31'b0, exp_wr_n});
    app_req_ack = 1'b1;
    @(negedge wb_clk);
    app_req_ack = 1'b0;
    chk("req_drop", {31'b0, app_req}, 32'd0);
  endtask

  task automatic wr_beat(input logic [31:0] d);
    wb_dati     = d;
    app_wr_next = 1'b1;
    #1;
    chk("wr_ack", {31'b0, wb_ack}, 32'd1);
    @(negedge wb_clk);
    app_wr_next = 1'b0;
  endtask

  task automatic rd_beat(input logic [31:0] d, input logic exp_ack);
    app_rd_valid = 1'b1;
    app_rd_data  = d;
    #1;
    chk("rd_ack_early", {31'b0, wb_ack}, 32'd0);
    @(negedge wb_clk);
    app_rd_valid = 1'b0;
    #1;
    chk("rd_ack", {31'b0, wb_ack}, {31'b0, exp_ack});
    if (exp_ack) chk("rd_dato", wb_dato, d);
    @(negedge wb_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wb_rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_sel = 4'h0; wb_addr = '0; wb_dati = '0; wb_cti = 3'b000;
    cfg_colbits = 2'd0; app_req_ack = 1'b0; app_wr_next = 1'b0;
    app_rd_data = '0; app_rd_valid = 1'b0;

    // Reset values
    @(negedge wb_clk);
    @(negedge wb_clk);
    chk("rst_ack", {31'b0, wb_ack}, 32'd0);
    chk("rst_req", {31'b0, app_req}, 32'd0);
    chk("rst_dato", wb_dato, 32'd0);
    chk("rst_addr", {8'b0, app_req_addr}, 32'd0);
    chk("rst_len", {23'b0, app_req_len}, 32'd1);
    chk("rst_wr_n", {31'b0, app_req_wr_n}, 32'd1);
    chk("rst_en_n", {28'b0, app_wr_en_n}, 32'hF);
    wb_rst = 1'b0;

    // Single write, request held until acked
    wb_sel  = 4'b0011;
    wb_dati = 32'hA5A5_1234;
    start(1'b1, 26'h10, 3'b000);
    @(negedge wb_clk);
    @(negedge wb_clk);
    chk("wr_req_held", {31'b0, app_req}, 32'd1);
    chk("wr_req_addr_held", {8'b0, app_req_addr}, 32'h4);
    req_handshake(24'h4, 9'd1, 1'b0);
    chk("wr_en_n", {28'b0, app_wr_en_n}, 32'hC);
    chk("wr_data", app_wr_data, 32'hA5A5_1234);
    chk("wr_no_ack_wait", {31'b0, wb_ack}, 32'd0);
    wr_beat(32'hA5A5_1234);
    stop();
    #1;
    chk("wr_en_n_idle", {28'b0, app_wr_en_n}, 32'hF);

    // Single read
    wb_sel = 4'hF;
    start(1'b0, 26'h20, 3'b000);
    req_handshake(24'h8, 9'd1, 1'b1);
    rd_beat(32'hDEAD_BEEF, 1'b1);
    stop();
    #1;
    chk("rd_no_restart", {31'b0, app_req}, 32'd0);

    // IDLE ignores app-side beats
    @(negedge wb_clk);
    app_wr_next = 1'b1; app_rd_valid = 1'b1; app_rd_data = 32'h1234_5678;
    #1;
    chk("idle_wr_next", {31'b0, wb_ack}, 32'd0);
    @(negedge wb_clk);
    app_wr_next = 1'b0; app_rd_valid = 1'b0;
    #1;
    chk("idle_rd_valid", {31'b0, wb_ack}, 32'd0);
    chk("idle_dato_hold", wb_dato, 32'hDEAD_BEEF);

    // Write beat with wb_stb low is stalled, not counted
    start(1'b1, 26'h40, 3'b000);
    req_handshake(24'h10, 9'd1, 1'b0);
    wb_stb = 1'b0;
    app_wr_next = 1'b1;
    #1;
    chk("stall_no_ack", {31'b0, wb_ack}, 32'd0);
    @(negedge wb_clk);
    wb_stb = 1'b1;
    #1;
    chk("stall_then_ack", {31'b0, wb_ack}, 32'd1);
    @(negedge wb_clk);
    app_wr_next = 1'b0;
    stop();

`ifdef WB_MODPORT_BURST_EN
    // 8-beat burst write from word 0
    start(1'b1, 26'h0, 3'b010);
    req_handshake(24'h0, 9'd8, 1'b0);
    for (int i = 0; i < 8; i++) wr_beat(32'h100 + i);
    // Back in IDLE: app_wr_next is ignored while the next burst is presented
    wb_addr = 26'h3F8;
    app_wr_next = 1'b1;
    #1;
    chk("burst_wr_done_idle", {31'b0, wb_ack}, 32'd0);
    app_wr_next = 1'b0;
    // Page-truncated burst at word 0xFE
    req_handshake(24'hFE, 9'd2, 1'b0);
    wr_beat(32'h200);
    wr_beat(32'h201);
    stop();

    // Burst read abandoned after 3 beats; remaining 5 drained silently
    start(1'b0, 26'h0, 3'b010);
    req_handshake(24'h0, 9'd8, 1'b1);
    for (int i = 0; i < 3; i++) rd_beat(32'h300 + i, 1'b1);
    stop();
    for (int i = 0; i < 5; i++) rd_beat(32'h400 + i, 1'b0);
    chk("drain_dato_hold", wb_dato, 32'h302);
    start(1'b1, 26'h80, 3'b000);
    req_handshake(24'h20, 9'd1, 1'b0);
    wr_beat(32'h500);
    stop();
`else
    // INCR cycle type is ignored: single requests only
    start(1'b1, 26'h0, 3'b010);
    req_handshake(24'h0, 9'd1, 1'b0);
    wr_beat(32'h100);
    stop();
    start(1'b0, 26'h3F8, 3'b010);
    req_handshake(24'hFE, 9'd1, 1'b1);
    rd_beat(32'h77, 1'b1);
    stop();
`endif

    // Reset while waiting for read data
    start(1'b0, 26'h30, 3'b000);
    req_handshake(24'hC, 9'd1, 1'b1);
    wb_rst = 1'b1;
    #1;
    chk("mid_rst_ack", {31'b0, wb_ack}, 32'd0);
    chk("mid_rst_req", {31'b0, app_req}, 32'd0);
    chk("mid_rst_wr_n", {31'b0, app_req_wr_n}, 32'd1);
    stop();
    @(negedge wb_clk);
    wb_rst = 1'b0;
    app_rd_valid = 1'b1;
    app_rd_data  = 32'h5555_AAAA;
    @(negedge wb_clk);
    app_rd_valid = 1'b0;
    #1;
    chk("post_rst_no_ack", {31'b0, wb_ack}, 32'd0);
    start(1'b0, 26'h44, 3'b000);
    req_handshake(24'h11, 9'd1, 1'b1);
    rd_beat(32'hCAFE_F00D, 1'b1);
    stop();

    @(negedge wb_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
